prbs_check: RTL and testbench

PRBS_CHECK -- requirements
Module: prbs_check

---
 rtl/prbs_check.sv | 163 ++++++++++++++++
 tb/tb_prbs_check.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prbs_check.sv
// Self-synchronising PRBS checker: per-bit error vector, lock
// tracking and a saturating count of error bits seen while locked.
module prbs_check #(
    parameter int unsigned           LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter bit                    REVERSE      = 1'b0,
    parameter int unsigned           DATA_WIDTH   = 64,
    parameter int unsigned           LOCK_COUNT   = 8,
    parameter int unsigned           UNLOCK_COUNT = 4,
    parameter int unsigned           COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    input  logic                   err_count_clear,
    output logic [DATA_WIDTH-1:0]  err_out,
    output logic                   word_err,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] bit_err_count
);

    localparam int unsigned PCW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned SW  =
        ((COUNT_WIDTH > PCW) ? COUNT_WIDTH : PCW) + 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    logic [LFSR_WIDTH-1:0]  hist_q, hist_d;
    logic [DATA_WIDTH-1:0]  err_q, err_d;
    logic                   word_err_q;
    logic                   v1_q;
    state_e                 state_q, state_d;
    logic [7:0]             good_q, good_d;
    logic [7:0]             bad_q, bad_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PCW-1:0]         pop;
    logic [SW-1:0]          sum;

    // hist bit k-1 is the received bit k positions back in time
    always_comb begin
        logic [LFSR_WIDTH-1:0] sh;
        logic                  b;
        logic                  fb;
        int                    idx;
        sh    = hist_q;
        err_d = '0;
        for (int t = 0; t < DATA_WIDTH; t++) begin
            idx = REVERSE ? t : int'(DATA_WIDTH) - 1 - t;
            b   = data_in[idx];
            fb  = sh[LFSR_WIDTH-1];
            for (int j = 1; j < LFSR_WIDTH; j++) begin
                if (LFSR_POLY[j]) begin
                    fb = fb ^ sh[j-1];
                end
            end
            err_d[idx] = b ^ fb;
            sh = {sh[LFSR_WIDTH-2:0], b};
        end
        hist_d = sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q     <= '0;
            err_q      <= '0;
            word_err_q <= 1'b0;
            v1_q       <= 1'b0;
        end else begin
            if (data_in_valid) begin
                hist_q <= hist_d;
                err_q  <= err_d;
            end
            word_err_q <= data_in_valid && (err_d != '0);
            v1_q       <= data_in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (v1_q) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (word_err_q) begin
                        good_d = '0;
                    end else if ({1'b0, good_q} + 9'd1 ==
                                 9'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end
                LOCKED: begin
                    if (!word_err_q) begin
                        bad_d = '0;
                    end else if ({1'b0, bad_q} + 9'd1 ==
                                 9'(UNLOCK_COUNT)) begin
                        state_d = UNLOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    // clear beats a same-edge increment; the sum saturates at all-ones
    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pop = pop + PCW'(err_q[i]);
        end
        sum   = SW'(cnt_q) + SW'(pop);
        cnt_d = cnt_q;
        if (err_count_clear) begin
            cnt_d = '0;
        end else if (v1_q && (state_q == LOCKED)) begin
            if (sum > SW'({COUNT_WIDTH{1'b1}})) begin
                cnt_d = '1;
            end else begin
                cnt_d = sum[COUNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_out       = err_q;
    assign word_err      = word_err_q;
    assign bit_err_count = cnt_q;

endmodule

// File: tb/tb_prbs_check.sv
// Directed bench for prbs_check: lock, single-bit errors, unlock,
// saturation, clear priority, valid gaps and mid-stream reset.
module tb_prbs_check;

    logic        clk = 1'b0;
    logic        r0, v0, c0, r1, v1, c1;
    logic [63:0] d0, d1;
    logic [63:0] eo0, eo1;
    logic        we0, we1, lk0, lk1;
    logic [31:0] bc0;
    logic [7:0]  bc1;
    logic [30:0] gs;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    prbs_check u0 (
        .clk(clk), .rst(r0), .data_in(d0), .data_in_valid(v0),
        .err_count_clear(c0), .err_out(eo0), .word_err(we0),
        .locked(lk0), .bit_err_count(bc0)
    );

    prbs_check #(.COUNT_WIDTH(8), .UNLOCK_COUNT(8)) u1 (
        .clk(clk), .rst(r1), .data_in(d1), .data_in_valid(v1),
        .err_count_clear(c1), .err_out(eo1), .word_err(we1),
        .locked(lk1), .bit_err_count(bc1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PRBS31 generator, b[n] = b[n-31] ^ b[n-28], MSB oldest
    task automatic gen(output logic [63:0] w);
        logic b;
        for (int t = 0; t < 64; t++) begin
            b = gs[30] ^ gs[27];
            w[63-t] = b;
            gs = {gs[29:0], b};
        end
    endtask

    task automatic send0(input logic [63:0] w);
        d0 = w;
        v0 = 1'b1;
        tick();
    endtask

    task automatic flip0(input logic [63:0] m);
        logic [63:0] w;
        gen(w);
        send0(w ^ m);
    endtask

    task automatic clean0();
        flip0(64'd0);
    endtask

    task automatic send1(input logic [63:0] w);
        d1 = w;
        v1 = 1'b1;
        tick();
    endtask

    task automatic clean1();
        logic [63:0] w;
        gen(w);
        send1(w);
    endtask

    initial begin
        logic [31:0] cb;
        int          seen;
        r0 = 1'b1; v0 = 1'b0; c0 = 1'b0; d0 = '0;
        r1 = 1'b1; v1 = 1'b0; c1 = 1'b0; d1 = '0;
        gs = '1;
        repeat (2) tick();
        chk("rst_locked", 64'(lk0), 64'd0);
        chk("rst_werr", 64'(we0), 64'd0);
        chk("rst_cnt", 64'(bc0), 64'd0);
        chk("rst_errout", eo0, 64'd0);

        // first word errs against zero history, words 2..9 lock
        r0 = 1'b0;
        repeat (9) clean0();
        chk("lock_w9", 64'(lk0), 64'd0);
        clean0();
        chk("lock_w10", 64'(lk0), 64'd1);
        chk("lock_cnt", 64'(bc0), 64'd0);

        seen = 0;
        repeat (1000) begin
            clean0();
            if (we0 || !lk0) seen++;
        end
        chk("clean1000_werr", 64'(seen), 64'd0);
        chk("clean1000_cnt", 64'(bc0), 64'd0);

        // flip at time 53: errors at 53 now, 81 and 84 next word
        flip0(64'h0000_0000_0000_0400);
        chk("flip_errout", eo0, 64'h0000_0000_0000_0400);
        chk("flip_werr", 64'(we0), 64'd1);
        clean0();
        chk("flip_errout2", eo0, 64'h0000_4800_0000_0000);
        chk("flip_werr2", 64'(we0), 64'd1);
        clean0();
        chk("flip_werr3", 64'(we0), 64'd0);
        chk("flip_cnt", 64'(bc0), 64'd3);
        chk("flip_locked", 64'(lk0), 64'd1);

        // flip at time 0: errors at 0, 28, 31 in one word
        flip0(64'h8000_0000_0000_0000);
        chk("clr_errout", eo0, 64'h8000_0009_0000_0000);
        c0 = 1'b1;
        clean0();
        chk("clr_prio", 64'(bc0), 64'd0);
        c0 = 1'b0;
        clean0();
        chk("clr_after", 64'(bc0), 64'd0);

        flip0(64'h0000_0000_0000_0400);
        repeat (2) clean0();
        chk("gap_pre", 64'(bc0), 64'd3);
        v0 = 1'b0;
        repeat (10) tick();
        chk("gap_locked", 64'(lk0), 64'd1);
        chk("gap_cnt", 64'(bc0), 64'd3);
        repeat (3) clean0();
        chk("gap_resume_cnt", 64'(bc0), 64'd3);
        chk("gap_resume_werr", 64'(we0), 64'd0);

        c0 = 1'b1;
        clean0();
        c0 = 1'b0;
        chk("clr_idle", 64'(bc0), 64'd0);

        // flips at 0,3,6: errors 0,3,6,28,37 (31 and 34 cancel)
        flip0(64'h9200_0000_0000_0000);
        chk("five_errout", eo0, 64'h9200_0008_0400_0000);
        clean0();
        chk("five_cnt", 64'(bc0), 64'd5);

        r0 = 1'b1;
        clean0();
        r0 = 1'b0;
        chk("mid_rst_locked", 64'(lk0), 64'd0);
        chk("mid_rst_cnt", 64'(bc0), 64'd0);
        chk("mid_rst_werr", 64'(we0), 64'd0);
        chk("mid_rst_errout", eo0, 64'd0);
        for (int i = 0; i < 12 && !lk0; i++) clean0();
        chk("relock_rst", 64'(lk0), 64'd1);
        chk("relock_rst_cnt", 64'(bc0), 64'd0);

        cb = bc0;
        repeat (4) send0('1);
        chk("ones_pre", 64'(lk0), 64'd1);
        clean0();
        chk("ones_unlock", 64'(lk0), 64'd0);
        chk("ones_cnt", 64'((bc0 - cb) >= 32'd192), 64'd1);
        for (int i = 0; i < 12 && !lk0; i++) clean0();
        chk("ones_relock", 64'(lk0), 64'd1);
        v0 = 1'b0;

        r1 = 1'b0;
        for (int i = 0; i < 14 && !lk1; i++) clean1();
        chk("sat_lock", 64'(lk1), 64'd1);
        chk("sat_cnt0", 64'(bc1), 64'd0);
        repeat (8) send1('1);
        clean1();
        chk("sat_cnt", 64'(bc1), 64'd255);
        chk("sat_unlock", 64'(lk1), 64'd0);
        repeat (2) clean1();
        chk("sat_hold", 64'(bc1), 64'd255);
        c1 = 1'b1;
        clean1();
        c1 = 1'b0;
        chk("sat_clr", 64'(bc1), 64'd0);
        v1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
